// File: rtl/alu_pipe.sv
// Pipelined RV32I integer execution unit between the reservation station and the ROB.
// Stage 1 computes value/next-PC/flags; later slots only carry the result toward out_*.
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_pred_taken,
  input  logic [ROB_W-1:0]  in_rob_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROB_W-1:0]  out_rob_id,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] out_target_pc,
  output logic              out_jump,
  output logic              out_mispredict,
  output logic              out_illegal
);

  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(1);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(18);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(22);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(23);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(24);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(27);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(28);

  typedef struct packed {
    logic [ROB_W-1:0]  rob_id;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] target_pc;
    logic              jump;
    logic              mispredict;
    logic              illegal;
  } slot_t;

  logic signed [DATA_W-1:0] rs1_s, rs2_s, imm_s;
  logic [DATA_W-1:0]        pc_plus4, pc_plus_imm, rs1_plus_imm;
  logic [4:0]               shamt_r, shamt_i;
  logic                     cond, ctrl, stall, advance;
  slot_t                    res_c;
  slot_t                    slot_p [STAGES];
  logic [STAGES-1:0]        vld_p;

  assign rs1_s        = in_rs1;
  assign rs2_s        = in_rs2;
  assign imm_s        = in_imm;
  assign pc_plus4     = in_pc + DATA_W'(4);
  assign pc_plus_imm  = in_pc + in_imm;
  assign rs1_plus_imm = in_rs1 + in_imm;
  assign shamt_r      = in_rs2[4:0];
  assign shamt_i      = in_imm[4:0];

  // A full output slot the ROB will not take freezes every slot; no bubble collapse.
  assign stall    = vld_p[STAGES-1] && !out_ready;
  assign advance  = rdy && !flush && !stall;
  assign in_ready = !rst && advance;

  // ---- stage 1: compute ----
  always_comb begin
    res_c           = '0;
    res_c.rob_id    = in_rob_id;
    res_c.target_pc = pc_plus4;
    ctrl            = 1'b0;
    case (in_op)
      OP_BEQ:  cond = (in_rs1 == in_rs2);
      OP_BNE:  cond = (in_rs1 != in_rs2);
      OP_BLT:  cond = (rs1_s < rs2_s);
      OP_BGE:  cond = (rs1_s >= rs2_s);
      OP_BLTU: cond = (in_rs1 < in_rs2);
      OP_BGEU: cond = (in_rs1 >= in_rs2);
      default: cond = 1'b0;
    endcase
    case (in_op)
      OP_LUI:   res_c.value = in_imm;
      OP_AUIPC: res_c.value = pc_plus_imm;
      OP_JAL: begin
        res_c.value     = pc_plus4;
        res_c.target_pc = pc_plus_imm;
        res_c.jump      = 1'b1;
        ctrl            = 1'b1;
      end
      OP_JALR: begin
        res_c.value     = pc_plus4;
        res_c.target_pc = {rs1_plus_imm[DATA_W-1:1], 1'b0};
        res_c.jump      = 1'b1;
        ctrl            = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_c.value     = DATA_W'(cond);
        res_c.jump      = cond;
        res_c.target_pc = cond ? pc_plus_imm : pc_plus4;
        ctrl            = 1'b1;
      end
      OP_ADD:   res_c.value = in_rs1 + in_rs2;
      OP_SUB:   res_c.value = in_rs1 - in_rs2;
      OP_SLL:   res_c.value = in_rs1 << shamt_r;
      OP_SLT:   res_c.value = DATA_W'(rs1_s < rs2_s);
      OP_SLTU:  res_c.value = DATA_W'(in_rs1 < in_rs2);
      OP_XOR:   res_c.value = in_rs1 ^ in_rs2;
      OP_SRL:   res_c.value = in_rs1 >> shamt_r;
      OP_SRA:   res_c.value = rs1_s >>> shamt_r;
      OP_OR:    res_c.value = in_rs1 | in_rs2;
      OP_AND:   res_c.value = in_rs1 & in_rs2;
      OP_ADDI:  res_c.value = rs1_plus_imm;
      OP_SLTI:  res_c.value = DATA_W'(rs1_s < imm_s);
      OP_SLTIU: res_c.value = DATA_W'(in_rs1 < in_imm);
      OP_XORI:  res_c.value = in_rs1 ^ in_imm;
      OP_ORI:   res_c.value = in_rs1 | in_imm;
      OP_ANDI:  res_c.value = in_rs1 & in_imm;
      OP_SLLI:  res_c.value = in_rs1 << shamt_i;
      OP_SRLI:  res_c.value = in_rs1 >> shamt_i;
      OP_SRAI:  res_c.value = rs1_s >>> shamt_i;
      default:  res_c.illegal = 1'b1;
    endcase
    res_c.mispredict = ctrl && (res_c.jump != in_pred_taken);
  end

  // ---- slot valid bits: flush clears them but leaves slot data untouched ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (rdy) begin
      if (flush) begin
        vld_p <= '0;
      end else if (!stall) begin
        vld_p[0] <= in_valid;
        for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // ---- stage 1 .. STAGES: result carry ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) slot_p[i] <= '0;
    end else if (advance) begin
      slot_p[0] <= res_c;
      for (int i = 1; i < STAGES; i++) slot_p[i] <= slot_p[i-1];
    end
  end

  assign out_valid      = vld_p[STAGES-1];
  assign out_rob_id     = slot_p[STAGES-1].rob_id;
  assign out_value      = slot_p[STAGES-1].value;
  assign out_target_pc  = slot_p[STAGES-1].target_pc;
  assign out_jump       = slot_p[STAGES-1].jump;
  assign out_mispredict = slot_p[STAGES-1].mispredict;
  assign out_illegal    = slot_p[STAGES-1].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, back-pressure and flush sequences,
// then random traffic checked against an in-order arithmetic reference model.
module tb_alu_pipe;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 6;
  localparam int STAGES = 2;

  localparam logic [5:0] LUI = 0, AUIPC = 1, JAL = 2, JALR = 3, BEQ = 4, BNE = 5;
  localparam logic [5:0] BLT = 6, BGE = 7, BLTU = 8, BGEU = 9, ADD = 10, SUB = 11;
  localparam logic [5:0] SLL = 12, SLT = 13, SLTU = 14, XOR = 15, SRL = 16, SRA = 17;
  localparam logic [5:0] OR = 18, AND = 19, ADDI = 20, SLTI = 21, SLTIU = 22;
  localparam logic [5:0] XORI = 23, ORI = 24, ANDI = 25, SLLI = 26, SRLI = 27, SRAI = 28;

  logic clk, rst, rdy, flush, in_valid, in_ready, in_pred_taken;
  logic [OP_W-1:0] in_op;
  logic [DATA_W-1:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [ROB_W-1:0] in_rob_id, out_rob_id;
  logic out_valid, out_ready, out_jump, out_mispredict, out_illegal;
  logic [DATA_W-1:0] out_value, out_target_pc;

  alu_pipe #(.DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_rob_id(in_rob_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_id(out_rob_id),
    .out_value(out_value), .out_target_pc(out_target_pc), .out_jump(out_jump),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [31:0] target;
    logic        jump;
    logic        misp;
    logic        ill;
  } res_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc, rs1, rs2, imm;
    logic        pred;
    logic [31:0] value, target;
    logic        jump, misp, ill;
  } vec_t;

  typedef struct {
    res_t       r;
    logic [3:0] rob;
  } exp_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[15];
  exp_t q[$];
  exp_t e;
  res_t rr;
  logic [5:0] r_op;
  logic [31:0] r_a, r_b, r_imm, r_pc;
  logic r_pred, held, saw_block;
  logic [31:0] snap_value, snap_target;
  logic [6:0] snap_flags;
  int sent, got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic pred,
                          input logic [3:0] rob);
    in_op = op; in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm;
    in_pred_taken = pred; in_rob_id = rob; in_valid = 1'b1;
  endtask

  task automatic chk_out(input string nm, input res_t r, input logic [3:0] rob);
    chk({nm, ".rob"}, 32'(out_rob_id), 32'(rob));
    chk({nm, ".value"}, out_value, r.value);
    chk({nm, ".target"}, out_target_pc, r.target);
    chk({nm, ".flags"}, {29'b0, out_jump, out_mispredict, out_illegal},
        {29'b0, r.jump, r.misp, r.ill});
  endtask

  function automatic longint floor_shr(input longint x, input int sh);
    longint d, qt;
    d  = longint'(1) << sh;
    qt = x / d;
    if ((x % d != 0) && (x < 0)) qt = qt - 1;
    return qt;
  endfunction

  // Reference: RV32I rules expressed with 64-bit integer arithmetic.
  function automatic res_t ref_alu(input logic [5:0] op, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic pred);
    res_t r;
    longint sa, sb, si, ua, ub, ui;
    int shr, shi;
    logic ctl, br, take;
    sa = longint'($signed(a)); sb = longint'($signed(b)); si = longint'($signed(imm));
    ua = longint'(a); ub = longint'(b); ui = longint'(imm);
    shr = int'(b[4:0]); shi = int'(imm[4:0]);
    r.value = 32'd0; r.target = pc + 32'd4; r.jump = 1'b0; r.misp = 1'b0; r.ill = 1'b0;
    ctl = 1'b0; br = 1'b0; take = 1'b0;
    case (op)
      LUI:   r.value = imm;
      AUIPC: r.value = pc + imm;
      JAL:   begin r.value = pc + 32'd4; r.target = pc + imm; r.jump = 1'b1; ctl = 1'b1; end
      JALR:  begin
        r.value = pc + 32'd4; r.target = (a + imm) & 32'hFFFF_FFFE; r.jump = 1'b1; ctl = 1'b1;
      end
      BEQ:   begin br = 1'b1; take = (ua == ub); end
      BNE:   begin br = 1'b1; take = (ua != ub); end
      BLT:   begin br = 1'b1; take = (sa < sb); end
      BGE:   begin br = 1'b1; take = (sa >= sb); end
      BLTU:  begin br = 1'b1; take = (ua < ub); end
      BGEU:  begin br = 1'b1; take = (ua >= ub); end
      ADD:   r.value = 32'(ua + ub);
      SUB:   r.value = 32'(ua - ub);
      SLL:   r.value = 32'(ua * (longint'(1) << shr));
      SLT:   r.value = (sa < sb) ? 32'd1 : 32'd0;
      SLTU:  r.value = (ua < ub) ? 32'd1 : 32'd0;
      XOR:   r.value = a ^ b;
      SRL:   r.value = 32'(ua / (longint'(1) << shr));
      SRA:   r.value = 32'(floor_shr(sa, shr));
      OR:    r.value = a | b;
      AND:   r.value = a & b;
      ADDI:  r.value = 32'(sa + si);
      SLTI:  r.value = (sa < si) ? 32'd1 : 32'd0;
      SLTIU: r.value = (ua < ui) ? 32'd1 : 32'd0;
      XORI:  r.value = a ^ imm;
      ORI:   r.value = a | imm;
      ANDI:  r.value = a & imm;
      SLLI:  r.value = 32'(ua * (longint'(1) << shi));
      SRLI:  r.value = 32'(ua / (longint'(1) << shi));
      SRAI:  r.value = 32'(floor_shr(sa, shi));
      default: r.ill = 1'b1;
    endcase
    if (br) begin
      ctl = 1'b1;
      r.value = {31'b0, take};
      r.jump = take;
      if (take) r.target = pc + imm;
    end
    r.misp = ctl && (r.jump != pred);
    return r;
  endfunction

  initial begin
    //          op     pc            rs1           rs2           imm           pred  value         target        j     m     ill
    vecs[0]  = '{ADDI, 32'h10,       32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 32'h0,        32'h14,       1'b0, 1'b0, 1'b0};
    vecs[1]  = '{SRA,  32'h20,       32'h80000000, 32'h21,       32'h0,        1'b0, 32'hC0000000, 32'h24,       1'b0, 1'b0, 1'b0};
    vecs[2]  = '{SRLI, 32'h24,       32'h80000000, 32'h0,        32'h4,        1'b0, 32'h08000000, 32'h28,       1'b0, 1'b0, 1'b0};
    vecs[3]  = '{BLT,  32'h100,      32'hFFFFFFFF, 32'h1,        32'h20,       1'b0, 32'h1,        32'h120,      1'b1, 1'b1, 1'b0};
    vecs[4]  = '{BLTU, 32'h100,      32'hFFFFFFFF, 32'h1,        32'h20,       1'b0, 32'h0,        32'h104,      1'b0, 1'b0, 1'b0};
    vecs[5]  = '{JALR, 32'h40,       32'h1001,     32'h0,        32'h2,        1'b1, 32'h44,       32'h1002,     1'b1, 1'b0, 1'b0};
    vecs[6]  = '{JAL,  32'h200,      32'h0,        32'h0,        32'hFFFFFFF0, 1'b0, 32'h204,      32'h1F0,      1'b1, 1'b1, 1'b0};
    vecs[7]  = '{LUI,  32'h8,        32'h0,        32'h0,        32'h12345000, 1'b0, 32'h12345000, 32'hC,        1'b0, 1'b0, 1'b0};
    vecs[8]  = '{AUIPC,32'hFFFFFFFC, 32'h0,        32'h0,        32'h8,        1'b0, 32'h4,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[9]  = '{SLTIU,32'h30,       32'h5,        32'h0,        32'hFFFFFFFF, 1'b0, 32'h1,        32'h34,       1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'd63,32'h50,       32'h7,        32'h9,        32'h3,        1'b1, 32'h0,        32'h54,       1'b0, 1'b0, 1'b1};
    vecs[11] = '{BGE,  32'h60,       32'h80000000, 32'h0,        32'h10,       1'b1, 32'h0,        32'h64,       1'b0, 1'b1, 1'b0};
    vecs[12] = '{SUB,  32'h70,       32'h0,        32'h1,        32'h0,        1'b0, 32'hFFFFFFFF, 32'h74,       1'b0, 1'b0, 1'b0};
    vecs[13] = '{SLT,  32'h78,       32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 32'h1,        32'h7C,       1'b0, 1'b0, 1'b0};
    vecs[14] = '{BNE,  32'h80,       32'h3,        32'h3,        32'h8,        1'b0, 32'h0,        32'h84,       1'b0, 1'b0, 1'b0};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_op = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    in_pred_taken = 1'b0; in_rob_id = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    rr = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    chk_out("rst", rr, 4'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed vectors, one op at a time
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive_op(vecs[i].op, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pred, 4'(i));
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (STAGES - 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd1);
      rr = '{vecs[i].value, vecs[i].target, vecs[i].jump, vecs[i].misp, vecs[i].ill};
      chk_out($sformatf("vec%0d", i), rr, 4'(i));
    end

    // Back-pressure: four ADDs while the ROB refuses results for three cycles
    @(posedge clk); #1;
    sent = 0; got = 0; saw_block = 1'b0; held = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      out_ready = (cyc >= 3);
      if (sent < 4)
        drive_op(ADD, 32'h400 + 32'(sent * 4), 32'(sent * 16 + 1), 32'h100, 32'h0, 1'b0, 4'(sent));
      else
        in_valid = 1'b0;
      @(negedge clk);
      if (!in_ready) saw_block = 1'b1;
      if (held) begin
        chk("bp.hold_value", out_value, snap_value);
        chk("bp.hold_rob", 32'(out_rob_id), 32'(snap_flags[6:3]));
      end
      if (out_valid && out_ready) begin
        chk("bp.order_rob", 32'(out_rob_id), 32'(got));
        chk("bp.value", out_value, 32'(got * 16 + 257));
        got++;
      end
      held = out_valid && !out_ready;
      snap_value = out_value;
      snap_flags = {out_rob_id, out_jump, out_mispredict, out_illegal};
      if (in_valid && in_ready) sent++;
    end
    chk("bp.got", 32'(got), 32'd4);
    chk("bp.sent", 32'(sent), 32'd4);
    chk("bp.in_ready_dropped", 32'(saw_block), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp.no_dup", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Flush with two ops in flight and the output stalled
    out_ready = 1'b0;
    drive_op(ADD, 32'h300, 32'h1, 32'h2, 32'h0, 1'b0, 4'd5);
    @(posedge clk); #1 drive_op(ADD, 32'h304, 32'h3, 32'h4, 32'h0, 1'b0, 4'd6);
    @(posedge clk); #1;
    flush = 1'b1;
    drive_op(ADD, 32'h308, 32'h9, 32'h9, 32'h0, 1'b0, 4'hF);
    @(negedge clk);
    chk("fl.in_ready", 32'(in_ready), 32'd0);
    chk("fl.pre_valid", 32'(out_valid), 32'd1);
    chk("fl.pre_rob", 32'(out_rob_id), 32'd5);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    drive_op(ADDI, 32'h30C, 32'h10, 32'h0, 32'h20, 1'b0, 4'd7);
    @(negedge clk);
    chk("fl.valid_cleared", 32'(out_valid), 32'd0);
    chk("fl.rob_kept", 32'(out_rob_id), 32'd5);
    chk("fl.value_kept", out_value, 32'd3);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < STAGES - 1; k++) begin
      @(negedge clk);
      chk("fl.early", 32'(out_valid), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("fl.after.valid", 32'(out_valid), 32'd1);
    rr = '{32'h30, 32'h310, 1'b0, 1'b0, 1'b0};
    chk_out("fl.after", rr, 4'd7);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("fl.no_stale", 32'(out_valid), 32'd0);
    end

    // Reset with an op in flight
    @(posedge clk); #1 drive_op(LUI, 32'h0, 32'h0, 32'h0, 32'hABCD0000, 1'b0, 4'd9);
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mrst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.value", out_value, 32'd0);
    chk("mrst.rob", 32'(out_rob_id), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("mrst.dropped", 32'(out_valid), 32'd0);

    // Random traffic against the reference model
    q.delete();
    held = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      r_op  = ($urandom_range(0, 4) != 0) ? 6'($urandom_range(0, 28)) : 6'($urandom_range(29, 63));
      r_a   = $urandom;
      r_b   = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
      r_imm = $urandom;
      r_pc  = $urandom & 32'hFFFF_FFFC;
      r_pred = 1'($urandom_range(0, 1));
      drive_op(r_op, r_pc, r_a, r_b, r_imm, r_pred, 4'(cyc));
      in_valid = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      chk("rnd.in_ready", 32'(in_ready), 32'(rdy && !flush && !(out_valid && !out_ready)));
      if (held) begin
        chk("rnd.hold_value", out_value, snap_value);
        chk("rnd.hold_target", out_target_pc, snap_target);
        chk("rnd.hold_flags", 32'({out_rob_id, out_jump, out_mispredict, out_illegal}),
            32'(snap_flags));
      end
      if (out_valid && q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rnd.spurious actual=out_valid=1 expected=no result pending");
      end
      if (rdy && flush) begin
        q.delete();
      end else if (rdy) begin
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk_out("rnd.retire", e.r, e.rob);
        end
        if (in_valid && in_ready) begin
          e.r = ref_alu(r_op, r_pc, r_a, r_b, r_imm, r_pred);
          e.rob = 4'(cyc);
          q.push_back(e);
        end
      end
      held = out_valid && !(rdy && (out_ready || flush));
      snap_value = out_value;
      snap_target = out_target_pc;
      snap_flags = {out_rob_id, out_jump, out_mispredict, out_illegal};
    end

    // Drain whatever the model still expects
    for (int k = 0; k < STAGES + 4; k++) begin
      @(posedge clk); #1;
      rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL drain.spurious actual=out_valid=1 expected=no result pending");
        end else begin
          e = q.pop_front();
          chk_out("drain", e.r, e.rob);
        end
      end
    end
    chk("drain.lost", 32'(q.size()), 32'd0);
    chk("drain.idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer execution unit for the out-of-order RV32I core. It sits between the reservation station and the reorder buffer. It accepts one op per cycle under a valid/ready handshake and computes the result, next PC and taken flag over a configurable number of stages. New over the previous ALU: back-pressure from the ROB, flush on misprediction, a branch-mispredict flag, an illegal-op flag, and correct shift and JALR semantics.

## Interface
- DATA_W, 32, datapath and PC width
- ROB_W, 4, ROB tag width
- OP_W, 6, op-ID width (shared op-ID encoding from the defines header)
- STAGES, 2, result latency in cycles, legal range 1..4
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- rdy  in  1  global enable; low freezes all state
- flush  in  1  ROB misprediction clear; kills every in-flight op
- in_valid  in  1  RS presents an op
- in_ready  out  1  unit can accept this cycle
- in_op  in  OP_W  op ID (LUI..SRAI)
- in_pc  in  DATA_W  instruction PC
- in_rs1, in_rs2  in  DATA_W  operand values
- in_imm  in  DATA_W  sign-extended immediate
- in_pred_taken  in  1  fetch-stage prediction for branches/jumps
- in_rob_id  in  ROB_W  destination ROB tag
- out_valid  out  1  result available
- out_ready  in  1  ROB accepts the result
- out_rob_id  out  ROB_W  tag
- out_value  out  DATA_W  rd value, or 0/1 compare result for branches
- out_target_pc  out  DATA_W  architectural next PC
- out_jump  out  1  control transfer taken
- out_mispredict  out  1  out_jump != in_pred_taken for branch/JAL/JALR ops; 0 for all other ops
- out_illegal  out  1  op ID not in the ALU set

## Operation
- Pipeline: STAGES slots, each with a valid bit. Stage 1 does the full compute; later stages only carry registers. The last slot drives out_*.
- Accept when in_valid && in_ready && rdy && !flush.
- Stall: when last slot is valid && !out_ready, the whole pipeline holds. There is no bubble collapse.
- in_ready = rdy && !flush && !(last slot valid && !out_ready).
- LUI: value = imm.
- AUIPC: value = pc+imm.
- JAL: value = pc+4; target = pc+imm; jump = 1.
- JALR: value = pc+4; target = (rs1+imm) & ~1; jump = 1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: value = cond; jump = cond; target = cond ? pc+imm : pc+4. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
- R-type ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) and I-type ops (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI): standard RV32I.
  - Shift amount = low 5 bits of rs2/imm.
  - SRA/SRAI are arithmetic (signed shift).
  - SLTIU compares rs1 against the sign-extended imm, unsigned.
  - Non-control ops: target = pc+4, jump = 0.
- Illegal op: value 0, target pc+4, jump 0, out_illegal = 1. The op still completes so the ROB entry retires.
- All adds wrap modulo 2^DATA_W.

## Timing
- Reset: all valid bits 0. out_valid, out_jump, out_mispredict and out_illegal are 0; out_value, out_target_pc and out_rob_id are 0. in_ready is 0 during reset.
- Priority per edge: rst > !rdy (hold everything) > flush > stall > advance/accept.
- Latency: op accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles after presentation. Throughput is 1/cycle with no stalls.
- Output handshake: a result retires on an edge with out_valid && out_ready && rdy. While stalled, out_* stay bit-stable.
- flush: every valid bit clears on that edge, including a result whose handshake completes in the same cycle; the ROB discards it. The input is not accepted. out_valid = 0 after the edge. Other out_* fields keep their old values.
- rdy low together with flush: flush is ignored for that cycle.
- Mid-operation reset: all in-flight ops are dropped, with the same effect as flush plus output clear.

## Test plan
- STAGES=2, ADDI rs1=0xFFFFFFFF, imm=1, rob 3 → out_valid two cycles later; value 0x0, rob 3, target pc+4, jump 0.
- SRA rs1=0x80000000, rs2=0x21 → value 0xC0000000 (shift 1). SRLI imm=4 on 0x80000000 → 0x08000000.
- BLT rs1=-1, rs2=1, pc=0x100, imm=0x20, pred_taken=0 → jump 1, target 0x120, value 1, mispredict 1. Same op with BLTU → jump 0, target 0x104, mispredict 0.
- JALR rs1=0x1001, imm=2, pc=0x40, pred_taken=1 → value 0x44, target 0x1002, jump 1, mispredict 0.
- Back-pressure: stream 4 ADDs with out_ready low for 3 cycles → in_ready drops once the pipeline fills, output is held stable, all 4 results arrive in order with no loss or duplication.
- Flush with 2 ops in flight and the output stalled → out_valid=0 next cycle, no stale result later. An op accepted the cycle after flush emerges normally STAGES cycles later.
